// File: rtl/controle_pkg.sv
// -----------------------------------------------------------------------------
// controle_pkg
// Shared definitions for the multicycle control unit:
//   - estado_e   : 4-bit state codes driven on the fetch-stage 'estado' bus
//   - OP_*       : RISC-V subset opcodes recognised by the decoder
//   - F3_*       : branch funct3 values that can be taken
//   - pc_sel_e   : next-PC selection used between the FSM and gera_proximo_pc
//   - extrai_imm_b : B-type immediate extraction (13 bits, bit 0 always 0)
// -----------------------------------------------------------------------------
package controle_pkg;

  typedef enum logic [3:0] {
    ESTADO_FETCH     = 4'b0000,
    ESTADO_DECODE    = 4'b0001,
    ESTADO_EXECUTE   = 4'b0010,
    ESTADO_MEM       = 4'b0011,
    ESTADO_WRITEBACK = 4'b0100,
    ESTADO_HALT      = 4'b1111
  } estado_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    PC_KEEP    = 2'd0,
    PC_ADVANCE = 2'd1,
    PC_BRANCH  = 2'd2
  } pc_sel_e;

  // Byte offset of a B-type instruction; the LSB is implicit zero.
  function automatic logic [12:0] extrai_imm_b(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/controle_multiciclo_gera_proximo_pc.sv
// -----------------------------------------------------------------------------
// gera_proximo_pc
// Combinational next-PC generator for the multicycle control unit.
// PC is word-indexed, so the byte branch offset is shifted right by 2.
// Ports:
//   pc         in  PC_WIDTH  current word address
//   imm_b      in  13        captured B-type immediate (signed, bytes)
//   funct3     in  3         captured funct3
//   zero       in  1         ALU zero flag
//   sel        in  pc_sel_e  keep / advance / conditional branch
//   proximo_pc out PC_WIDTH  next word address (wraps modulo 2^PC_WIDTH)
// -----------------------------------------------------------------------------
module gera_proximo_pc
  import controle_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [12:0]         imm_b,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  pc_sel_e             sel,
  output logic [PC_WIDTH-1:0] proximo_pc
);

  logic signed [PC_WIDTH-1:0] imm_ext;
  logic signed [PC_WIDTH-1:0] desloc;
  logic                       tomado;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_ext    = {{(PC_WIDTH-13){imm_b[12]}}, imm_b};
    desloc     = imm_ext >>> 2;
    tomado     = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
    proximo_pc = pc;
    case (sel)
      PC_ADVANCE: proximo_pc = pc + PC_WIDTH'(1);
      PC_BRANCH:  proximo_pc = tomado ? (pc + PC_WIDTH'(desloc)) : (pc + PC_WIDTH'(1));
      default:    proximo_pc = pc;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multicycle control/sequencing unit sitting in front of the fetch stage.
// Owns the word-indexed PC and the 'estado' code; the fetch stage loads
// instrucao <= mem[PC] on the edge that leaves FETCH. Decodes the captured
// opcode, steps through per-class states, drives datapath enables and halts
// once PC reaches NUM_INSTR.
// Ports:
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous, active-high
//   instrucao  in   32        instruction, valid from DECODE
//   zero       in   1         ALU zero flag, valid in EXECUTE
//   PC         out  PC_WIDTH  word address to the fetch stage
//   estado     out  4         current state code
//   reg_write, mem_read, mem_write, alu_src  out  datapath enables
//   done       out  1         program finished (HALT)
//   illegal    out  1         sticky unknown-opcode flag
// Build option: define ILLEGAL_TRAP_EN to halt on an unknown opcode (PC kept
// at the offending word); otherwise it is executed as a NOP.
// -----------------------------------------------------------------------------
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int NUM_INSTR = 15,
  parameter int PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instrucao,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] PC,
  output logic [3:0]          estado,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                done,
  output logic                illegal
);

  estado_e             state_q, state_d;
  pc_sel_e             pc_sel;
  logic                marca_ilegal;
  logic [6:0]          opcode_q;
  logic [2:0]          funct3_q;
  logic [12:0]         imm_b_q;
  logic [PC_WIDTH-1:0] proximo_pc;

  // Register-index fields are the datapath's business, not the sequencer's.
  logic unused_campos;
  assign unused_campos = ^instrucao[24:15];

  gera_proximo_pc #(.PC_WIDTH(PC_WIDTH)) u_gera_proximo_pc (
    .pc         (PC),
    .imm_b      (imm_b_q),
    .funct3     (funct3_q),
    .zero       (zero),
    .sel        (pc_sel),
    .proximo_pc (proximo_pc)
  );

  // Next-state and PC selection.
  always_comb begin
    state_d      = state_q;
    pc_sel       = PC_KEEP;
    marca_ilegal = 1'b0;
    case (state_q)
      ESTADO_FETCH:
        state_d = (PC >= PC_WIDTH'(NUM_INSTR)) ? ESTADO_HALT : ESTADO_DECODE;
      ESTADO_DECODE:
        state_d = ESTADO_EXECUTE;
      ESTADO_EXECUTE:
        case (opcode_q)
          OP_R, OP_I:        state_d = ESTADO_WRITEBACK;
          OP_LOAD, OP_STORE: state_d = ESTADO_MEM;
          OP_BRANCH: begin
            state_d = ESTADO_FETCH;
            pc_sel  = PC_BRANCH;
          end
          default: begin
            marca_ilegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d = ESTADO_HALT;
`else
            state_d = ESTADO_FETCH;
            pc_sel  = PC_ADVANCE;
`endif
          end
        endcase
      ESTADO_MEM:
        if (opcode_q == OP_LOAD) begin
          state_d = ESTADO_WRITEBACK;
        end else begin
          state_d = ESTADO_FETCH;
          pc_sel  = PC_ADVANCE;
        end
      ESTADO_WRITEBACK: begin
        state_d = ESTADO_FETCH;
        pc_sel  = PC_ADVANCE;
      end
      ESTADO_HALT:
        state_d = ESTADO_HALT;
      default:
        state_d = ESTADO_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: reset is synchronous; all control state including the captured
  // instruction fields is cleared so an aborted instruction leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ESTADO_FETCH;
      PC       <= '0;
      opcode_q <= '0;
      funct3_q <= '0;
      imm_b_q  <= '0;
      illegal  <= 1'b0;
    end else begin
      state_q <= state_d;
      PC      <= proximo_pc;
      if (state_q == ESTADO_DECODE) begin
        opcode_q <= instrucao[6:0];
        funct3_q <= instrucao[14:12];
        imm_b_q  <= extrai_imm_b(instrucao);
      end
      if (marca_ilegal) illegal <= 1'b1;
    end
  end

  // Enables depend only on state and the captured opcode.
  always_comb begin
    estado    = state_q;
    reg_write = (state_q == ESTADO_WRITEBACK);
    mem_read  = (state_q == ESTADO_MEM) && (opcode_q == OP_LOAD);
    mem_write = (state_q == ESTADO_MEM) && (opcode_q == OP_STORE);
    alu_src   = (opcode_q inside {OP_I, OP_LOAD, OP_STORE}) &&
                (state_q inside {ESTADO_EXECUTE, ESTADO_MEM, ESTADO_WRITEBACK});
    done      = (state_q == ESTADO_HALT);
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Directed bench for controle_multiciclo. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_SW   = 32'h0020A023;  // sw   x2,0(x1)
  localparam logic [31:0] I_BEQ8 = 32'h00000463;  // beq  +8 bytes
  localparam logic [31:0] I_BNEM = 32'hFE001CE3;  // bne  -8 bytes
  localparam logic [31:0] I_BLT8 = 32'h00004463;  // funct3=100, never taken
  localparam logic [31:0] I_UNK  = 32'h0000007F;  // unknown opcode

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrucao;
  logic        zero;
  logic [31:0] PC;
  logic [3:0]  estado;
  logic        reg_write, mem_read, mem_write, alu_src, done, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clk       (clk),
    .reset     (reset),
    .instrucao (instrucao),
    .zero      (zero),
    .PC        (PC),
    .estado    (estado),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .done      (done),
    .illegal   (illegal)
  );

  function automatic logic [3:0] enables();
    return {reg_write, mem_read, mem_write, alu_src};
  endfunction

  // Stimulus helpers (called at a falling edge).
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_r(input int n);
    repeat (n) begin
      instrucao = I_ADD;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [3:0]  exp_est [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h0};
    logic [3:0]  exp_en  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [31:0] exp_pc  [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    reset = 1'b1; instrucao = I_ADD; zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (estado !== 4'h0 || PC !== 32'd0) begin
      errors++; $display("FAIL reset_state: estado=%h PC=%0d required 0/0", estado, PC);
    end
    checks++;
    if ({enables(), done, illegal} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: %b required 000000", {enables(), done, illegal});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (estado !== exp_est[i] || enables() !== exp_en[i] || PC !== exp_pc[i]) begin
        errors++;
        $display("FAIL add_cycle%0d: estado=%h en=%b PC=%0d required %h/%b/%0d",
                 i, estado, enables(), PC, exp_est[i], exp_en[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0]  exp_est [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    logic [3:0]  exp_en  [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b1001, 4'b0000};
    logic [31:0] exp_pc  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
    run_r(1);  // PC 1 -> 2
    instrucao = I_LW;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (estado !== exp_est[i] || enables() !== exp_en[i] || PC !== exp_pc[i]) begin
        errors++;
        $display("FAIL load_cycle%0d: estado=%h en=%b PC=%0d required %h/%b/%0d",
                 i, estado, enables(), PC, exp_est[i], exp_en[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [3:0]  exp_est [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
    logic [3:0]  exp_en  [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000};
    logic [31:0] exp_pc  [5] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd4};
    instrucao = I_SW;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (estado !== exp_est[i] || enables() !== exp_en[i] || PC !== exp_pc[i]) begin
        errors++;
        $display("FAIL store_cycle%0d: estado=%h en=%b PC=%0d required %h/%b/%0d",
                 i, estado, enables(), PC, exp_est[i], exp_en[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] vec_instr [5] = '{I_BEQ8, I_BEQ8, I_BNEM, I_BNEM, I_BLT8};
    logic        vec_zero  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] vec_pc    [5] = '{32'd6, 32'd5, 32'd2, 32'd5, 32'd5};
    logic [3:0]  exp_est   [4] = '{4'h0, 4'h1, 4'h2, 4'h0};
    for (int v = 0; v < 5; v++) begin
      apply_reset(1);
      run_r(4);  // PC 0 -> 4
      instrucao = vec_instr[v];
      zero      = vec_zero[v];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (estado !== exp_est[i] || enables() !== 4'b0000) begin
          errors++;
          $display("FAIL branch%0d_cycle%0d: estado=%h en=%b required %h/0000",
                   v, i, estado, enables(), exp_est[i]);
        end
      end
      checks++;
      if (PC !== vec_pc[v]) begin
        errors++; $display("FAIL branch%0d_pc: PC=%0d required %0d", v, PC, vec_pc[v]);
      end
      zero = 1'b0;
    end
  endtask

  task automatic test_halt();
    apply_reset(1);
    run_r(15);  // PC 0 -> 15
    checks++;
    if (estado !== 4'h0 || PC !== 32'd15 || done !== 1'b0) begin
      errors++; $display("FAIL halt_pre: estado=%h PC=%0d done=%b required 0/15/0", estado, PC, done);
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      checks++;
      if (estado !== 4'hF || PC !== 32'd15 || done !== 1'b1 || enables() !== 4'b0000) begin
        errors++;
        $display("FAIL halt_hold%0d: estado=%h PC=%0d done=%b en=%b required F/15/1/0000",
                 i, estado, PC, done, enables());
      end
    end
    apply_reset(1);
    checks++;
    if (estado !== 4'h0 || PC !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL halt_reset: estado=%h PC=%0d done=%b required 0/0/0", estado, PC, done);
    end
    // Negative branch target from PC 0 wraps and ends the program.
    instrucao = I_BNEM; zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (estado !== 4'h0 || PC !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL wrap_pc: estado=%h PC=%h required 0/fffffffe", estado, PC);
    end
    @(negedge clk);
    checks++;
    if (estado !== 4'hF || done !== 1'b1 || PC !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL wrap_halt: estado=%h done=%b PC=%h required F/1/fffffffe", estado, done, PC);
    end
  endtask

  task automatic test_illegal();
    apply_reset(1);
    run_r(7);  // PC 0 -> 7
    instrucao = I_UNK;
    repeat (2) @(negedge clk);
    checks++;
    if (estado !== 4'h2 || illegal !== 1'b0 || enables() !== 4'b0000) begin
      errors++; $display("FAIL illegal_exec: estado=%h illegal=%b en=%b required 2/0/0000", estado, illegal, enables());
    end
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if (estado !== 4'hF || PC !== 32'd7 || illegal !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL illegal_trap: estado=%h PC=%0d illegal=%b done=%b required F/7/1/1", estado, PC, illegal, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (estado !== 4'hF || PC !== 32'd7) begin
      errors++; $display("FAIL illegal_trap_hold: estado=%h PC=%0d required F/7", estado, PC);
    end
`else
    checks++;
    if (estado !== 4'h0 || PC !== 32'd8 || illegal !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL illegal_nop: estado=%h PC=%0d illegal=%b done=%b required 0/8/1/0", estado, PC, illegal, done);
    end
    run_r(1);
    checks++;
    if (PC !== 32'd9 || illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: PC=%0d illegal=%b required 9/1", PC, illegal);
    end
`endif
    apply_reset(1);
    checks++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: illegal=%b done=%b required 0/0", illegal, done);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1);
    run_r(1);  // PC 0 -> 1
    instrucao = I_SW;
    repeat (3) @(negedge clk);
    checks++;
    if (estado !== 4'h3 || mem_write !== 1'b1) begin
      errors++; $display("FAIL mid_mem: estado=%h mem_write=%b required 3/1", estado, mem_write);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (estado !== 4'h0 || PC !== 32'd0 || enables() !== 4'b0000) begin
      errors++; $display("FAIL mid_abort: estado=%h PC=%0d en=%b required 0/0/0000", estado, PC, enables());
    end
    reset = 1'b0;
    run_r(1);
    checks++;
    if (estado !== 4'h0 || PC !== 32'd1) begin
      errors++; $display("FAIL mid_resume: estado=%h PC=%0d required 0/1", estado, PC);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
